rvc_asap_mem_loader: RTL

RVC_ASAP_MEM_LOADER -- requirements
Module: rvc_asap_mem_loader

---
 rtl/rvc_asap_mem_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rvc_asap_mem_loader.sv
// Byte-stream boot loader for rvc_asap: parses {ADDR, LEN, data} frames into the
// shared memory write port, then hands that port to the core until LdStart.
module rvc_asap_mem_loader #(
    parameter logic [31:0] MEM_MSB = 32'h0000_FFFF
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        LdValid,
    input  logic [7:0]  LdData,
    output logic        LdReady,
    input  logic        LdStart,
    input  logic        CoreWrEn,
    input  logic [31:0] CoreWrAddr,
    input  logic [7:0]  CoreWrData,
    output logic        MemWrEn,
    output logic [31:0] MemWrAddr,
    output logic [7:0]  MemWrData,
    output logic        CoreRst,
    output logic        LdDone,
    output logic        LdErr
);

    typedef enum logic [1:0] {HDR, DATA, RUN, ERR} state_t;

    state_t      state, next_state;
    logic [2:0]  hdr_cnt;
    logic [31:0] addr;
    logic [31:0] len;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        core_rst_q;

    logic        xfer;
    logic [31:0] len_full;
    logic [32:0] last_byte;
    logic        in_range;

    assign LdReady  = (state == HDR) || (state == DATA);
    assign xfer     = LdValid && LdReady;

    // Header fields arrive LSB first, so each byte shifts in from the top.
    assign len_full  = {LdData, len[31:8]};
    assign last_byte = {1'b0, addr} + {1'b0, len_full} - 33'd1;
    assign in_range  = (last_byte <= {1'b0, MEM_MSB});

    // NOTE: next_state gets its hold value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            HDR: begin
                if (xfer && hdr_cnt == 3'd7) begin
                    if (len_full == 32'd0) next_state = RUN;
                    else if (in_range)     next_state = DATA;
                    else                   next_state = ERR;
                end
            end
            DATA:    if (xfer && len == 32'd1) next_state = HDR;
            RUN:     if (LdStart) next_state = HDR;
            ERR:     if (LdStart) next_state = HDR;
            default: next_state = HDR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) state <= HDR;
        else      state <= next_state;
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            hdr_cnt    <= 3'd0;
            addr       <= 32'd0;
            len        <= 32'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 8'd0;
            core_rst_q <= 1'b1;
        end else begin
            wr_en_q    <= 1'b0;
            // Release the core one cycle after entering RUN; re-assert as soon as RUN is left.
            core_rst_q <= (state != RUN) || (next_state != RUN);
            case (state)
                HDR: begin
                    if (xfer) begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                        if (!hdr_cnt[2]) addr <= {LdData, addr[31:8]};
                        else             len  <= len_full;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr;
                        wr_data_q <= LdData;
                        addr      <= addr + 32'd1;
                        len       <= len - 32'd1;
                    end
                end
                RUN, ERR: begin
                    if (LdStart) begin
                        hdr_cnt <= 3'd0;
                        addr    <= 32'd0;
                        len     <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The core owns the write port only in RUN; the final loader write may land in HDR.
    assign MemWrEn   = (state == RUN) ? CoreWrEn   : wr_en_q;
    assign MemWrAddr = (state == RUN) ? CoreWrAddr : wr_addr_q;
    assign MemWrData = (state == RUN) ? CoreWrData : wr_data_q;

    assign CoreRst = core_rst_q;
    assign LdDone  = (state == RUN);
    assign LdErr   = (state == ERR);

endmodule
